// File: rtl/mem_bridge_if.sv
// Cache-controller side of mem_bridge: request levels, write-back data,
// refill data and completion/busy status.
interface mem_bridge_if;
  logic [29:0] addr;
  logic [31:0] wb_data;
  logic        mem_write_ce;
  logic        mem_read_ce;
  logic [31:0] mem_data;
  logic        mem_write_fin;
  logic        mem_read_fin;
  logic        busy;

  modport master (
    output addr, wb_data, mem_write_ce, mem_read_ce,
    input  mem_data, mem_write_fin, mem_read_fin, busy
  );

  modport slave (
    input  addr, wb_data, mem_write_ce, mem_read_ce,
    output mem_data, mem_write_fin, mem_read_fin, busy
  );
endinterface

// File: rtl/mem_bridge.sv
// Memory-side stage behind the cache controller: turns write-back/refill
// request edges into timed accesses on a single-port word-addressed RAM.
module mem_bridge #(
  parameter int unsigned AW        = 16,
  parameter int unsigned READ_LAT  = 4,
  parameter int unsigned WRITE_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bridge_if.slave   cif,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WFIN, S_READ, S_RFIN} state_t;

  localparam logic [7:0] WR_LAST = 8'(WRITE_LAT - 1);
  localparam logic [7:0] RD_LAST = 8'(READ_LAT - 1);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_cnt;
  logic          r_wce_q, r_rce_q;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem_data;
  logic          r_pw_v, r_pr_v;
  logic [AW-1:0] r_pw_addr, r_pr_addr;
  logic [31:0]   r_pw_data;

  logic w_wr_req, w_rd_req;
  logic w_enter_wr, w_enter_rd;
  logic w_wr_to_slot, w_rd_to_slot;
  logic w_unused_addr;

  // Upper address bits are deliberately dropped: addresses alias in the RAM.
  assign w_unused_addr = &{1'b0, cif.addr};

  assign w_wr_req = cif.mem_write_ce & ~r_wce_q;
  assign w_rd_req = cif.mem_read_ce  & ~r_rce_q;

  always_comb begin
    w_state_nxt       = r_state;
    ram_en            = 1'b0;
    ram_we            = 1'b0;
    cif.mem_write_fin = 1'b0;
    cif.mem_read_fin  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_req || r_pw_v)      w_state_nxt = S_WRITE;
        else if (w_rd_req || r_pr_v) w_state_nxt = S_READ;
      end
      S_WRITE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        if (r_cnt == WR_LAST) w_state_nxt = S_WFIN;
      end
      S_WFIN: begin
        cif.mem_write_fin = 1'b1;
        w_state_nxt = (r_pr_v || w_rd_req) ? S_READ : S_IDLE;
      end
      S_READ: begin
        ram_en = 1'b1;
        if (r_cnt == RD_LAST) w_state_nxt = S_RFIN;
      end
      S_RFIN: begin
        cif.mem_read_fin = 1'b1;
        w_state_nxt = r_pw_v ? S_WRITE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_wr = (w_state_nxt == S_WRITE) && (r_state != S_WRITE);
  assign w_enter_rd = (w_state_nxt == S_READ)  && (r_state != S_READ);

  // An edge is served directly only when its slot is empty; otherwise it
  // parks in the slot, which is allowed when the slot is freed this cycle.
  assign w_wr_to_slot = w_wr_req && (r_pw_v ? w_enter_wr : !w_enter_wr);
  assign w_rd_to_slot = w_rd_req && (r_pr_v ? w_enter_rd : !w_enter_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wce_q    <= 1'b0;
      r_rce_q    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_data <= '0;
      r_pw_v     <= 1'b0;
      r_pr_v     <= 1'b0;
      r_pw_addr  <= '0;
      r_pr_addr  <= '0;
      r_pw_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 8'd1;
      r_wce_q <= cif.mem_write_ce;
      r_rce_q <= cif.mem_read_ce;

      if (w_enter_wr) begin
        r_addr  <= r_pw_v ? r_pw_addr : cif.addr[AW-1:0];
        r_wdata <= r_pw_v ? r_pw_data : cif.wb_data;
      end else if (w_enter_rd) begin
        r_addr  <= r_pr_v ? r_pr_addr : cif.addr[AW-1:0];
      end

      if (w_wr_to_slot) begin
        r_pw_v    <= 1'b1;
        r_pw_addr <= cif.addr[AW-1:0];
        r_pw_data <= cif.wb_data;
      end else if (w_enter_wr) begin
        r_pw_v    <= 1'b0;
      end

      if (w_rd_to_slot) begin
        r_pr_v    <= 1'b1;
        r_pr_addr <= cif.addr[AW-1:0];
      end else if (w_enter_rd) begin
        r_pr_v    <= 1'b0;
      end

      if (r_state == S_READ && r_cnt == RD_LAST) r_mem_data <= ram_rdata;
    end
  end

  assign ram_addr     = r_addr;
  assign ram_wdata    = r_wdata;
  assign cif.mem_data = r_mem_data;
  assign cif.busy     = (r_state != S_IDLE) || r_pw_v || r_pr_v;
endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Memory-side stage directly downstream of the cache controller.
- Turns the controller's `mem_write_ce`/`mem_read_ce` requests (write-back of a dirty line word, refill of a missed word) into timed accesses on a word-addressed, single-port backing RAM.
- Returns `mem_write_fin`/`mem_read_fin` completion pulses and the refill word on `mem_data`.
- Serialises a write-back ahead of a refill when both are requested together.

Parameters:
- AW, 16: backing RAM word-address width; `ram_addr = addr[AW-1:0]`; legal range 1..30.
- READ_LAT, 4: cycles from `ram_en` assertion to valid `ram_rdata`; legal range 1..255.
- WRITE_LAT, 3: cycles `ram_we` is held per write; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  30  word address from the cache controller.
- wb_data  in  32  write-back data from the cache.
- mem_write_ce  in  1  write-back request (level; acted on at its rising edge).
- mem_read_ce  in  1  refill request (level; acted on at its rising edge).
- mem_data  out  32  refill word; held until the next read completes.
- mem_write_fin  out  1  one-cycle pulse: write complete.
- mem_read_fin  out  1  one-cycle pulse: `mem_data` valid.
- busy  out  1  high while an access is in progress or pending.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset state: state=IDLE; counter=0; pending flags=0; ce edge registers=0; all outputs=0 (including `mem_data`).
- Reset is asynchronous. Asserting `rst_n` low mid-access aborts the access immediately: `ram_we` and `ram_en` drop with no fin pulse, and any pending request is discarded.
- Edge detect: `wr_req = mem_write_ce & ~wce_q` and `rd_req = mem_read_ce & ~rce_q`, where `wce_q`/`rce_q` are the ce inputs registered every cycle.
  - A ce held high after completion never retriggers an access.
  - A ce must drop for at least one cycle before a new request is recognised.
- Request capture: on a request edge, `addr` (and `wb_data` for a write) is latched into internal registers.
  - `ram_addr` and `ram_wdata` are driven only from these latched values.
  - Input changes after the edge are ignored.
  - A request edge arriving while busy sets a pending flag with its own latched address/data. Each type has one pending slot; a second edge of the same type while that type is already pending is dropped.
- States:
  - IDLE: if `wr_req` or a pending write exists, go to WRITE. Otherwise, if `rd_req` or a pending read exists, go to READ. A write always wins over a simultaneous read, so the write-back precedes the refill.
  - WRITE: `ram_en=1`, `ram_we=1`; counter runs 0..WRITE_LAT-1. On the last count go to WFIN.
  - WFIN: `mem_write_fin=1` for exactly this one cycle, with `ram_en`/`ram_we` low. Then go to IDLE, or straight to READ if a read is pending or `rd_req` is asserted this cycle.
  - READ: `ram_en=1`, `ram_we=0`; counter runs 0..READ_LAT-1. On the last count, `mem_data <= ram_rdata`; go to RFIN.
  - RFIN: `mem_read_fin=1` for one cycle. Then go to IDLE, or to WRITE if a write is pending.
- Latency from the ce edge cycle (IDLE entry at edge+1):
  - Write: fin at cycle WRITE_LAT+1.
  - Read: fin at cycle READ_LAT+1, with `mem_data` valid in the same cycle as the fin.
- `busy` = state≠IDLE or any pending flag set.
- Counter is 8 bits and clears on every state entry; no wrap occurs within the legal parameter range.
- `ram_addr` upper address bits (`addr[29:AW]`) are ignored, i.e. addresses alias.

Test Plan:
- Reset, then a single write: `addr=0x10`, `wb_data=0xDEADBEEF`, `mem_write_ce` raised and held high.
  - Expect `ram_we` high for exactly 3 cycles at `ram_addr=0x10`.
  - Expect `mem_write_fin` as a single pulse at edge+4.
  - Expect no second write although ce stays high.
- Read after the write: `mem_read_ce` rises with `addr=0x10`; the RAM model returns 0xDEADBEEF after 4 cycles.
  - Expect `mem_read_fin` pulse at edge+5 with `mem_data=0xDEADBEEF`.
  - `mem_data` must remain 0xDEADBEEF after fin until the next read completes.
- Simultaneous rising `mem_write_ce` and `mem_read_ce` on the same cycle, with `addr=0x20`, `wb_data=0x12345678`.
  - Write completes first: fin at +4.
  - READ entered directly from WFIN; read fin at +9.
  - `busy` stays high from edge+1 through RFIN.
- Read edge arriving mid-write (cycle +2 of a write to 0x30, read of 0x31).
  - Read is pending and uses the latched address 0x31 even if `addr` changes afterward.
  - Read fin occurs after the write fin with no idle gap.
- `rst_n` pulsed low during READ cycle 2.
  - Outputs are 0 immediately (asynchronously).
  - No `mem_read_fin` pulse.
  - After release, a new read completes normally.
- Parameter sweep with READ_LAT=1 and WRITE_LAT=1: back-to-back write then read completes at +2 and +4; fin pulses are one cycle wide.
